// File: rtl/mem_access_unit.sv
// mem_access_unit
//   Load/store sequencer between the EX/MEM pipeline register and dataMemory.
//   Takes one byte-addressed request at a time (byte/half/word/doubleword).
//   Loads return little-endian lanes, sign- or zero-extended. Sub-doubleword
//   stores use a read-modify-write sequence. Each request ends with one response.
//
// Ports
//   clk, reset         single clock; synchronous active-high reset
//   req_valid/ready    request handshake; ready only while idle
//   req_write          1 = store, 0 = load
//   req_size           0 byte, 1 half, 2 word, 3 doubleword
//   req_signed         load extension select (ignored for doubleword)
//   req_addr           byte address
//   req_wdata          store data, low (8 << size) bits used
//   resp_valid/ready   response handshake; response held until accepted
//   resp_rdata         extended load data, zero for stores and errors
//   resp_err           misaligned request, memory untouched
//   Addr               doubleword index to dataMemory
//   writeData          write data to dataMemory
//   memWrite, memRead  dataMemory strobes (never asserted while reset is high)
//   readData           combinational read data from dataMemory
module mem_access_unit #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [1:0]          req_size,
    input  logic                req_signed,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [DATA_W-1:0]   resp_rdata,
    output logic                resp_err,
    output logic [ADDR_W-4:0]   Addr,
    output logic [DATA_W-1:0]   writeData,
    output logic                memWrite,
    output logic                memRead,
    input  logic [DATA_W-1:0]   readData
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LD_RD  = 3'd1,
        ST_WR  = 3'd2,
        RMW_RD = 3'd3,
        RMW_WR = 3'd4,
        RESP   = 3'd5
    } state_t;

    state_t              state_r;
    state_t              state_next_s;
    logic                misaligned_s;

    logic [1:0]          size_r;
    logic                signed_r;
    logic [2:0]          offset_r;
    logic [DATA_W-1:0]   wdata_r;
    logic [ADDR_W-4:0]   addr_r;
    logic [DATA_W-1:0]   write_data_r;
    logic [DATA_W-1:0]   resp_rdata_r;
    logic                resp_err_r;
    logic                resp_valid_r;
    logic                req_ready_r;
    logic                mem_read_r;
    logic                mem_write_r;

    // An access is misaligned when any address bit below its natural size is set.
    function automatic logic is_misaligned(input logic [2:0] addr_low, input logic [1:0] size);
        logic result;
        case (size)
            2'd0:    result = 1'b0;
            2'd1:    result = (addr_low[0] != 1'b0);
            2'd2:    result = (addr_low[1:0] != 2'b00);
            default: result = (addr_low != 3'b000);
        endcase
        return result;
    endfunction

    // Bit mask covering the low (8 << size) bits.
    function automatic logic [63:0] lane_mask(input logic [1:0] size);
        logic [63:0] mask;
        case (size)
            2'd0:    mask = 64'h0000_0000_0000_00FF;
            2'd1:    mask = 64'h0000_0000_0000_FFFF;
            2'd2:    mask = 64'h0000_0000_FFFF_FFFF;
            default: mask = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
        return mask;
    endfunction

    // Pull the little-endian lane at the byte offset out of a doubleword and extend it.
    function automatic logic [63:0] extract_lane(input logic [63:0] word, input logic [2:0] offset,
                                                 input logic [1:0] size, input logic sign_ext);
        logic [63:0] shifted;
        logic [63:0] result;
        shifted = word >> {offset, 3'b000};
        case (size)
            2'd0:    result = {{56{sign_ext & shifted[7]}},  shifted[7:0]};
            2'd1:    result = {{48{sign_ext & shifted[15]}}, shifted[15:0]};
            2'd2:    result = {{32{sign_ext & shifted[31]}}, shifted[31:0]};
            default: result = shifted;
        endcase
        return result;
    endfunction

    // Replace the target lane of the old doubleword with the low store bits; other bytes keep their value.
    function automatic logic [63:0] merge_lane(input logic [63:0] old_word, input logic [63:0] new_data,
                                               input logic [2:0] offset, input logic [1:0] size);
        logic [63:0] mask;
        logic [5:0]  shift;
        mask  = lane_mask(size);
        shift = {offset, 3'b000};
        return (old_word & ~(mask << shift)) | ((new_data & mask) << shift);
    endfunction

    assign misaligned_s = is_misaligned(req_addr[2:0], req_size);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; a request is taken only from IDLE.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (req_valid) begin
                    if (misaligned_s) begin
                        state_next_s = RESP;
                    end else if (!req_write) begin
                        state_next_s = LD_RD;
                    end else if (req_size == 2'd3) begin
                        state_next_s = ST_WR;
                    end else begin
                        state_next_s = RMW_RD;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            LD_RD:  state_next_s = RESP;
            ST_WR:  state_next_s = RESP;
            RMW_RD: state_next_s = RMW_WR;
            RMW_WR: state_next_s = RESP;
            RESP: begin
                if (resp_ready) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = RESP;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Request latch, merge buffer, response data and registered strobes that follow the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            size_r       <= 2'd0;
            signed_r     <= 1'b0;
            offset_r     <= 3'd0;
            wdata_r      <= '0;
            addr_r       <= '0;
            write_data_r <= '0;
            resp_rdata_r <= '0;
            resp_err_r   <= 1'b0;
            resp_valid_r <= 1'b0;
            req_ready_r  <= 1'b1;
            mem_read_r   <= 1'b0;
            mem_write_r  <= 1'b0;
        end else begin
            req_ready_r  <= (state_next_s == IDLE);
            resp_valid_r <= (state_next_s == RESP);
            mem_read_r   <= (state_next_s == LD_RD) || (state_next_s == RMW_RD);
            mem_write_r  <= (state_next_s == ST_WR) || (state_next_s == RMW_WR);
            case (state_r)
                IDLE: begin
                    if (req_valid) begin
                        size_r       <= req_size;
                        signed_r     <= req_signed;
                        offset_r     <= req_addr[2:0];
                        wdata_r      <= req_wdata;
                        addr_r       <= req_addr[ADDR_W-1:3];
                        // Doubleword stores write straight from the request; sub-doubleword
                        // stores overwrite this with the merged word one cycle later.
                        write_data_r <= req_wdata;
                        resp_rdata_r <= '0;
                        resp_err_r   <= misaligned_s;
                    end
                end
                LD_RD: begin
                    resp_rdata_r <= extract_lane(readData, offset_r, size_r,
                                                 signed_r & (size_r != 2'd3));
                end
                RMW_RD: begin
                    write_data_r <= merge_lane(readData, wdata_r, offset_r, size_r);
                end
                default: begin
                    write_data_r <= write_data_r;
                end
            endcase
        end
    end

    assign req_ready  = req_ready_r;
    assign resp_valid = resp_valid_r;
    assign resp_rdata = resp_rdata_r;
    assign resp_err   = resp_err_r;
    assign Addr       = addr_r;
    assign writeData  = write_data_r;
    // Strobes are masked by reset so memory is never touched in a reset cycle.
    assign memRead    = mem_read_r & ~reset;
    assign memWrite   = mem_write_r & ~reset;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [12:0] req_addr;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_rdata;
    logic        resp_err;
    logic [9:0]  mem_addr;
    logic [63:0] mem_wdata;
    logic        mem_write;
    logic        mem_read;
    logic [63:0] mem_rdata;

    int checks_total  = 0;
    int checks_passed = 0;

    // dataMemory stand-in and its strobe counters
    logic [63:0] dmem  [0:1023];
    logic [63:0] image [0:1023];
    logic        image_load;
    int          read_edges  = 0;
    int          write_edges = 0;

    // Reference model: flat byte-addressed memory
    logic [7:0]  ref_mem [0:8191];

    mem_access_unit #(.ADDR_W(13), .DATA_W(64)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .resp_err(resp_err),
        .Addr(mem_addr), .writeData(mem_wdata), .memWrite(mem_write),
        .memRead(mem_read), .readData(mem_rdata)
    );

    always #5 clk = ~clk;

    assign mem_rdata = dmem[mem_addr];

    // Behavioural dataMemory: image load, synchronous write, strobe counting.
    always @(posedge clk) begin
        if (image_load) begin
            for (int i = 0; i < 1024; i++) dmem[i] <= image[i];
        end else if (mem_write) begin
            dmem[mem_addr] <= mem_wdata;
        end
        if (mem_write) write_edges <= write_edges + 1;
        if (mem_read)  read_edges  <= read_edges + 1;
    end

    task automatic check_value(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks_total++;
        if (observed !== expected) begin
            $display("FAIL %s: observed %h expected %h", tag, observed, expected);
        end else begin
            checks_passed++;
        end
    endtask

    function automatic logic [63:0] model_load(input logic [12:0] addr, input logic [1:0] sz, input logic sgn);
        int nbytes;
        logic [63:0] v;
        nbytes = 1 << sz;
        v = 64'd0;
        for (int i = 0; i < nbytes; i++) v = v | (64'(ref_mem[int'(addr) + i]) << (8 * i));
        if (sgn && sz != 2'd3 && v[8 * nbytes - 1]) begin
            for (int i = 8 * nbytes; i < 64; i++) v[i] = 1'b1;
        end
        return v;
    endfunction

    task automatic model_store(input logic [12:0] addr, input logic [1:0] sz, input logic [63:0] wd);
        for (int i = 0; i < (1 << sz); i++) ref_mem[int'(addr) + i] = wd[8 * i +: 8];
    endtask

    // One full request/response transaction with optional response backpressure.
    task automatic run_txn(input string tag, input logic wr, input logic [1:0] sz, input logic sgn,
                           input logic [12:0] addr, input logic [63:0] wd, input int hold,
                           output logic [63:0] got);
        int nbytes, exp_lat, exp_rd, exp_wr, exp_reads, exp_writes;
        int r0, w0, cyc, rd_cyc, wr_cyc;
        logic mis;
        logic [63:0] exp_data;
        logic [63:0] held_data;
        logic held_err;
        nbytes   = 1 << sz;
        mis      = (int'(addr) % nbytes) != 0;
        exp_data = 64'd0;
        if (mis) begin
            exp_lat = 1; exp_rd = 0; exp_wr = 0;
        end else if (!wr) begin
            exp_lat = 2; exp_rd = 1; exp_wr = 0;
            exp_data = model_load(addr, sz, sgn);
        end else if (sz == 2'd3) begin
            exp_lat = 2; exp_rd = 0; exp_wr = 1;
            model_store(addr, sz, wd);
        end else begin
            exp_lat = 3; exp_rd = 1; exp_wr = 2;
            model_store(addr, sz, wd);
        end
        exp_reads  = (exp_rd != 0) ? 1 : 0;
        exp_writes = (exp_wr != 0) ? 1 : 0;

        req_valid = 1'b1; req_write = wr; req_size = sz; req_signed = sgn;
        req_addr = addr; req_wdata = wd;
        check_value($sformatf("%s_ready_idle", tag), 64'(req_ready), 64'd1);
        r0 = read_edges; w0 = write_edges;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        rd_cyc = 0; wr_cyc = 0;
        for (cyc = 1; cyc <= 8; cyc++) begin
            if (mem_read  && rd_cyc == 0) rd_cyc = cyc;
            if (mem_write && wr_cyc == 0) wr_cyc = cyc;
            if (resp_valid) break;
            @(negedge clk);
        end
        check_value($sformatf("%s_latency", tag), 64'(cyc), 64'(exp_lat));
        check_value($sformatf("%s_read_cycle", tag), 64'(rd_cyc), 64'(exp_rd));
        check_value($sformatf("%s_write_cycle", tag), 64'(wr_cyc), 64'(exp_wr));
        check_value($sformatf("%s_rdata", tag), resp_rdata, exp_data);
        check_value($sformatf("%s_err", tag), 64'(resp_err), 64'(mis));
        got = resp_rdata;
        held_data = resp_rdata;
        held_err  = resp_err;
        // Hold the response while offering a competing request that must be ignored.
        for (int h = 0; h < hold; h++) begin
            req_valid = 1'b1; req_write = 1'b1; req_size = 2'd3;
            req_addr = 13'($urandom); req_wdata = {$urandom, $urandom};
            @(negedge clk);
            check_value($sformatf("%s_hold_valid", tag), 64'(resp_valid), 64'd1);
            check_value($sformatf("%s_hold_data", tag), resp_rdata, held_data);
            check_value($sformatf("%s_hold_err", tag), 64'(resp_err), 64'(held_err));
            check_value($sformatf("%s_hold_ready", tag), 64'(req_ready), 64'd0);
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        check_value($sformatf("%s_resp_done", tag), 64'(resp_valid), 64'd0);
        check_value($sformatf("%s_ready_back", tag), 64'(req_ready), 64'd1);
        check_value($sformatf("%s_reads", tag), 64'(read_edges - r0), 64'(exp_reads));
        check_value($sformatf("%s_writes", tag), 64'(write_edges - w0), 64'(exp_writes));
    endtask

    initial begin
        logic [63:0] got;
        logic [1:0]  sz;
        logic [12:0] addr;
        int          idx, mism;
        logic [63:0] model_word;

        reset = 1'b1; image_load = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0; req_signed = 1'b0;
        req_addr = 13'd0; req_wdata = 64'd0; resp_ready = 1'b0;
        for (int i = 0; i < 1024; i++) image[i] = {$urandom, $urandom};
        image[1] = 64'h8877_6655_4433_2211;
        for (int i = 0; i < 1024; i++) begin
            for (int b = 0; b < 8; b++) ref_mem[i * 8 + b] = image[i][8 * b +: 8];
        end
        @(negedge clk);
        image_load = 1'b0;
        @(negedge clk);
        check_value("rst_req_ready", 64'(req_ready), 64'd1);
        check_value("rst_resp_valid", 64'(resp_valid), 64'd0);
        check_value("rst_resp_err", 64'(resp_err), 64'd0);
        check_value("rst_resp_rdata", resp_rdata, 64'd0);
        check_value("rst_strobes", 64'({mem_read, mem_write}), 64'd0);
        check_value("rst_addr", 64'(mem_addr), 64'd0);
        check_value("rst_wdata", mem_wdata, 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // Signed byte load with three cycles of response backpressure
        run_txn("t1_lb", 1'b0, 2'd0, 1'b1, 13'h00F, 64'd0, 3, got);
        check_value("t1_value", got, 64'hFFFF_FFFF_FFFF_FF88);
        run_txn("t2_lws", 1'b0, 2'd2, 1'b1, 13'h00C, 64'd0, 0, got);
        check_value("t2_signed", got, 64'hFFFF_FFFF_8877_6655);
        run_txn("t2_lwu", 1'b0, 2'd2, 1'b0, 13'h00C, 64'd0, 1, got);
        check_value("t2_unsigned", got, 64'h0000_0000_8877_6655);
        run_txn("t4_mis", 1'b0, 2'd3, 1'b0, 13'h00C, 64'd0, 0, got);

        // Reset during the write half of a halfword read-modify-write
        begin
            int w0;
            w0 = write_edges;
            req_valid = 1'b1; req_write = 1'b1; req_size = 2'd1; req_signed = 1'b0;
            req_addr = 13'h00A; req_wdata = 64'h0000_0000_0000_BEEF;
            @(posedge clk);
            @(negedge clk);
            req_valid = 1'b0;
            check_value("t6_rmw_read", 64'(mem_read), 64'd1);
            @(posedge clk);
            #1 reset = 1'b1;
            @(negedge clk);
            check_value("t6_write_gated", 64'(mem_write), 64'd0);
            @(negedge clk);
            reset = 1'b0;
            @(negedge clk);
            check_value("t6_ready", 64'(req_ready), 64'd1);
            check_value("t6_no_resp", 64'(resp_valid), 64'd0);
            check_value("t6_no_write", 64'(write_edges - w0), 64'd0);
        end
        run_txn("t6_ld", 1'b0, 2'd3, 1'b0, 13'h008, 64'd0, 0, got);
        check_value("t6_preserved", got, 64'h8877_6655_4433_2211);

        run_txn("t3_sh", 1'b1, 2'd1, 1'b0, 13'h00A, 64'h0000_0000_0000_BEEF, 0, got);
        run_txn("t3_ld", 1'b0, 2'd3, 1'b0, 13'h008, 64'd0, 0, got);
        check_value("t3_merged", got, 64'h8877_6655_BEEF_2211);

        // Last doubleword of the address space
        run_txn("top_sd", 1'b1, 2'd3, 1'b0, 13'h1FF8, 64'h80A1_B2C3_D4E5_F607, 0, got);
        run_txn("top_lb", 1'b0, 2'd0, 1'b1, 13'h1FFF, 64'd0, 0, got);
        check_value("top_value", got, 64'hFFFF_FFFF_FFFF_FF80);

        // Random mix over a small window so loads revisit stored data
        for (int n = 0; n < 80; n++) begin
            sz  = 2'($urandom_range(0, 3));
            idx = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 7) : $urandom_range(1016, 1023);
            if ($urandom_range(0, 4) == 0) begin
                addr = 13'(idx * 8 + $urandom_range(0, 7));
            end else begin
                addr = 13'(idx * 8 + ($urandom_range(0, 7) & ~((1 << sz) - 1)));
            end
            run_txn($sformatf("rnd%0d", n), 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
                    addr, {$urandom, $urandom}, $urandom_range(0, 2), got);
        end

        mism = 0;
        for (int i = 0; i < 1024; i++) begin
            model_word = model_load(13'(i * 8), 2'd3, 1'b0);
            if (dmem[i] !== model_word) mism++;
        end
        check_value("final_memory", 64'(mism), 64'd0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
